fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: machine word and the fetch bundle
// handed to the decode latch.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t imemAddr;
        word_t instr;
        word_t pc;
    } ifetch_t;

    localparam word_t WORD_BYTES = 32'd4;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch output latch and FETCH/FULL/HALTED control.
// Requests come only from registered state, so ihit never feeds back into imemREN/imemaddr.
//
// state  | meaning
// FETCH  | request outstanding at PC; an ihit loads the output latch
// FULL   | latch holds an instruction the stalled consumer has not taken
// HALTED | halt decoded; no further requests until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    ihit,
    input  word_t   imemload,
    output logic    imemREN,
    output word_t   imemaddr,
    input  logic    stall,
    input  logic    redirect,
    input  word_t   redirectAddr,
    input  logic    halt,
    output ifetch_t ifOut,
    output logic    ifValid
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t  state, state_next;
    word_t   pc, pc_next;
    ifetch_t out_next;
    logic    valid_next;
    // Cleared by reset so a late ihit belonging to an abandoned request is not taken
    // during the first cycle after reset deasserts.
    logic    armed;

    assign imemREN  = (state == FETCH) && armed;
    assign imemaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            ifOut   <= '0;
            ifValid <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ifOut   <= out_next;
            ifValid <= valid_next;
            armed   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        out_next   = ifOut;
        valid_next = ifValid;

        if (halt) begin
            state_next = HALTED;
            if (!stall) valid_next = 1'b0;
        end else if (redirect && (state != HALTED)) begin
            state_next = FETCH;
            pc_next    = align_word(redirectAddr);
            valid_next = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit && armed && !(ifValid && stall)) begin
                        out_next.imemAddr = pc;
                        out_next.instr    = imemload;
                        out_next.pc       = pc + WORD_BYTES;
                        pc_next           = pc + WORD_BYTES;
                        valid_next        = 1'b1;
                        if (stall) state_next = FULL;
                    end else if (!stall) begin
                        valid_next = 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        valid_next = 1'b0;
                        state_next = FETCH;
                    end
                end
                HALTED: begin
                    if (!stall) valid_next = 1'b0;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/FULL, redirect, halt, wrap and reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic    CLK;
    logic    RST;
    logic    ihit;
    word_t   imemload;
    logic    imemREN;
    word_t   imemaddr;
    logic    stall;
    logic    redirect;
    word_t   redirectAddr;
    logic    halt;
    ifetch_t ifOut;
    logic    ifValid;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .redirect(redirect), .redirectAddr(redirectAddr), .halt(halt),
        .ifOut(ifOut), .ifValid(ifValid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
        redirect = 1'b0; redirectAddr = '0; halt = 1'b0;
        step;
        step;
        check("rst_ren",   96'(imemREN), 96'd0);
        check("rst_valid", 96'(ifValid), 96'd0);
        check("rst_ifout", ifOut, 96'd0);
        check("rst_addr",  96'(imemaddr), 96'd0);

        // Release reset with a stale ihit present; it must be ignored
        RST = 1'b0; ihit = 1'b1; imemload = 32'hA0A0_A0A0;
        check("post_rst_ren0", 96'(imemREN), 96'd0);
        step;
        check("late_ihit_valid", 96'(ifValid), 96'd0);
        check("late_ihit_addr",  96'(imemaddr), 96'd0);
        check("armed_ren",       96'(imemREN), 96'd1);

        // Streaming fetch, ihit every cycle
        for (int i = 0; i < 3; i++) begin
            imemload = 32'h1000 + 32'(i);
            step;
            check("stream_valid", 96'(ifValid), 96'd1);
            check("stream_pc",    96'(ifOut.pc), 96'(4 * (i + 1)));
            check("stream_iaddr", 96'(ifOut.imemAddr), 96'(4 * i));
            check("stream_instr", 96'(ifOut.instr), 96'(32'h1000 + 32'(i)));
            check("stream_addr",  96'(imemaddr), 96'(4 * (i + 1)));
        end

        // No new ihit, consumer not stalled: ifValid drops
        ihit = 1'b0;
        step;
        check("drop_valid", 96'(ifValid), 96'd0);
        check("drop_addr",  96'(imemaddr), 96'h0c);

        // Misaligned redirect target gets low bits cleared
        redirect = 1'b1; redirectAddr = 32'h11;
        step;
        check("align_addr", 96'(imemaddr), 96'h10);
        redirect = 1'b0;

        // Load at 0x10 under stall -> FULL for 3 cycles
        ihit = 1'b1; imemload = 32'hDEAD_0010; stall = 1'b1;
        step;
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("full_valid", 96'(ifValid), 96'd1);
            check("full_instr", 96'(ifOut.instr), 96'hDEAD_0010);
            check("full_ren",   96'(imemREN), 96'd0);
            check("full_addr",  96'(imemaddr), 96'h14);
            if (i < 2) step;
        end
        stall = 1'b0;
        step;
        check("unstall_valid", 96'(ifValid), 96'd0);
        check("unstall_ren",   96'(imemREN), 96'd1);
        check("unstall_addr",  96'(imemaddr), 96'h14);

        // ihit while latch valid and stalled must not load
        ihit = 1'b1; imemload = 32'h0000_1414;
        step;
        check("ld14_pc", 96'(ifOut.pc), 96'h18);
        stall = 1'b1; imemload = 32'h0000_0BAD;
        step;
        check("hold_instr", 96'(ifOut.instr), 96'h1414);
        check("hold_addr",  96'(imemaddr), 96'h18);
        check("hold_ren",   96'(imemREN), 96'd1);
        check("hold_valid", 96'(ifValid), 96'd1);
        stall = 1'b0; imemload = 32'h0000_1818;
        step;
        check("ld18_instr", 96'(ifOut.instr), 96'h1818);
        check("ld18_addr",  96'(imemaddr), 96'h1c);
        imemload = 32'h0000_1C1C;
        step;
        check("at20_addr", 96'(imemaddr), 96'h20);

        // Redirect with simultaneous ihit at 0x20: ihit discarded
        redirect = 1'b1; redirectAddr = 32'h200; imemload = 32'h0000_2020;
        step;
        check("redir_valid", 96'(ifValid), 96'd0);
        check("redir_addr",  96'(imemaddr), 96'h200);
        check("redir_instr", 96'(ifOut.instr), 96'h1C1C);
        check("redir_ren",   96'(imemREN), 96'd1);

        // PC wrap at top of address space
        redirectAddr = 32'hFFFF_FFFC; ihit = 1'b0;
        step;
        redirect = 1'b0; ihit = 1'b1; imemload = 32'h0000_7777;
        step;
        check("wrap_pc",    96'(ifOut.pc), 96'd0);
        check("wrap_iaddr", 96'(ifOut.imemAddr), 96'hFFFF_FFFC);
        check("wrap_addr",  96'(imemaddr), 96'd0);
        check("wrap_valid", 96'(ifValid), 96'd1);

        // Halt beats redirect and ihit
        halt = 1'b1; redirect = 1'b1; redirectAddr = 32'h300; imemload = 32'h0000_9999;
        step;
        halt = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("halt_ren",   96'(imemREN), 96'd0);
            check("halt_addr",  96'(imemaddr), 96'd0);
            check("halt_valid", 96'(ifValid), 96'd0);
            step;
        end

        // Reset out of HALTED, then abandon a request waiting at 0x40
        RST = 1'b1; ihit = 1'b0;
        step;
        RST = 1'b0;
        step;
        redirect = 1'b1; redirectAddr = 32'h40;
        step;
        redirect = 1'b0;
        step;
        check("wait40_addr", 96'(imemaddr), 96'h40);
        check("wait40_ren",  96'(imemREN), 96'd1);
        #2 RST = 1'b1;
        #1;
        check("async_ren",  96'(imemREN), 96'd0);
        check("async_addr", 96'(imemaddr), 96'd0);
        step;
        RST = 1'b0; ihit = 1'b1; imemload = 32'h0000_4040;
        step;
        check("rst40_valid", 96'(ifValid), 96'd0);
        check("rst40_addr",  96'(imemaddr), 96'd0);
        check("rst40_ren",   96'(imemREN), 96'd1);
        imemload = 32'h0000_5050;
        step;
        check("resume_valid", 96'(ifValid), 96'd1);
        check("resume_instr", 96'(ifOut.instr), 96'h5050);
        check("resume_addr",  96'(imemaddr), 96'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
